// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the reconfigurable FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SUM  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int unsigned WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Accumulator width that holds the full-precision sum of every tap product.
  function automatic int unsigned accW(input int unsigned inW, input int unsigned coefW,
                                       input int unsigned nBank, input int unsigned taps);
    return inW + coefW + $clog2(nBank * taps);
  endfunction

  // Clamp a signed value into the range of an outW-bit signed number.
  function automatic wide_t saturate(input wide_t acc, input int unsigned outW);
    wide_t hi;
    wide_t lo;
    wide_t res;
    hi  = (wide_t'(1) <<< (outW - 1)) - wide_t'(1);
    lo  = -hi - wide_t'(1);
    res = acc;
    if (acc > hi) begin
      res = hi;
    end else if (acc < lo) begin
      res = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_mac_lane.sv
// One coefficient bank: TAPS-deep coefficient RAM, tap mux over its delay slice, signed MAC.
module fir_mac_lane
  import fir_pkg::*;
#(
  parameter int unsigned TAPS   = 10,
  parameter int unsigned IN_W   = 3,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned ACC_W  = 25,
  localparam int unsigned TAP_W = $clog2(TAPS)
) (
  input  logic                     iClk,
  input  logic                     iRsn,
  input  logic                     iWrEn,
  input  logic [TAP_W-1:0]         iAddr,
  input  logic [COEF_W-1:0]        iWtData,
  input  logic                     iRunRd,
  input  logic                     iActive,
  input  logic                     iAccClr,
  input  logic [TAPS*IN_W-1:0]     iDlySlice,
  output logic [COEF_W-1:0]        oCoefRd_c,
  output logic signed [ACC_W-1:0]  oAcc
);

  localparam int unsigned PROD_W = IN_W + COEF_W;

  logic [COEF_W-1:0]        mem [TAPS];
  logic signed [COEF_W-1:0] coefQ;
  logic signed [IN_W-1:0]   tapQ;
  logic                     accVld;
  logic signed [IN_W-1:0]   tap_c;
  logic signed [PROD_W-1:0] prod_c;

  // Access-port view of the addressed coefficient, and the tap selected for this step.
  always_comb begin
    oCoefRd_c = mem[iAddr];
    tap_c     = iDlySlice[int'(iAddr) * IN_W +: IN_W];
    prod_c    = PROD_W'(coefQ) * PROD_W'(tapQ);
  end

  // Coefficient RAM with registered read, operand pipeline and accumulator.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        mem[i] <= '0;
      end
      coefQ  <= '0;
      tapQ   <= '0;
      accVld <= 1'b0;
      oAcc   <= '0;
    end else begin
      if (iWrEn) begin
        mem[iAddr] <= iWtData;
      end
      if (iRunRd) begin
        coefQ <= mem[iAddr];
        tapQ  <= tap_c;
      end
      accVld <= iRunRd && iActive;
      if (iAccClr) begin
        oAcc <= '0;
      end else if (accVld) begin
        oAcc <= oAcc + ACC_W'(prod_c);
      end
    end
  end

endmodule

// File: rtl/fir_reconf_param.sv
// Reconfigurable multi-bank FIR: sample FSM, delay line, coefficient access, lane sum, saturation.
module fir_reconf_param
  import fir_pkg::*;
#(
  parameter int unsigned N_BANK = 4,
  parameter int unsigned TAPS   = 10,
  parameter int unsigned IN_W   = 3,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 0,
  localparam int unsigned BANK_W = (N_BANK > 1) ? $clog2(N_BANK) : 1,
  localparam int unsigned TAP_W  = $clog2(TAPS)
) (
  input  logic                    iClk12M,
  input  logic                    iRsn,
  input  logic                    iEnSample,
  input  logic signed [IN_W-1:0]  iFirIn,
  input  logic [BANK_W-1:0]       iNumBank,
  input  logic                    iCoeffWr,
  input  logic                    iCoeffRd,
  input  logic [BANK_W-1:0]       iBankSel,
  input  logic [TAP_W-1:0]        iCoeffAddr,
  input  logic [COEF_W-1:0]       iWtDtRam,
  output logic [COEF_W-1:0]       oRdDtRam,
  output logic                    oRdValid,
  output logic [OUT_W-1:0]        oFirOut,
  output logic                    oFirValid,
  output logic                    oBusy,
  output logic                    oOverrun,
  output logic                    oCoeffReject
);

  localparam int unsigned ACC_W = accW(IN_W, COEF_W, N_BANK, TAPS);
  localparam int unsigned DLY_W = N_BANK * TAPS * IN_W;
  localparam int unsigned CNT_W = $clog2(TAPS + 1);

  state_t                  state;
  state_t                  stateNext;
  logic [CNT_W-1:0]        tapCnt;
  logic [DLY_W-1:0]        dly;
  logic [BANK_W-1:0]       numBank;
  logic signed [ACC_W-1:0] sumReg;
  logic signed [ACC_W-1:0] laneAcc [N_BANK];
  logic [COEF_W-1:0]       laneCoef [N_BANK];

  logic                    idle_c;
  logic                    accept_c;
  logic                    accessOk_c;
  logic                    wrOk_c;
  logic                    rdOk_c;
  logic                    runRd_c;
  logic                    accClr_c;
  logic [TAP_W-1:0]        laneAddr_c;
  logic signed [ACC_W-1:0] sumAll_c;

  // Sample acceptance and coefficient access decode.
  always_comb begin
    idle_c     = (state == IDLE);
    accept_c   = iEnSample && idle_c;
    accessOk_c = idle_c && !iEnSample &&
                 (32'(iBankSel) < N_BANK) && (32'(iCoeffAddr) < TAPS);
    wrOk_c     = iCoeffWr && accessOk_c;
    rdOk_c     = iCoeffRd && !iCoeffWr && accessOk_c;
  end

  // State register.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: RUN covers TAPS reads plus one drain cycle for the last product.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (iEnSample) stateNext = RUN;
      RUN:  if (tapCnt == CNT_W'(TAPS)) stateNext = SUM;
      SUM:  stateNext = OUT;
      OUT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FSM control outputs to the lanes.
  always_comb begin
    runRd_c    = 1'b0;
    accClr_c   = 1'b0;
    laneAddr_c = iCoeffAddr;
    case (state)
      RUN: begin
        runRd_c    = (tapCnt < CNT_W'(TAPS));
        laneAddr_c = TAP_W'(tapCnt);
      end
      OUT:     accClr_c = 1'b1;
      default: ;
    endcase
  end

  // Lane array; lanes above the latched bank count never accumulate.
  for (genvar b = 0; b < int'(N_BANK); b++) begin : gLane
    fir_mac_lane #(
      .TAPS   (TAPS),
      .IN_W   (IN_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
    ) uLane (
      .iClk      (iClk12M),
      .iRsn      (iRsn),
      .iWrEn     (wrOk_c && (32'(iBankSel) == 32'(b))),
      .iAddr     (laneAddr_c),
      .iWtData   (iWtDtRam),
      .iRunRd    (runRd_c),
      .iActive   (32'(b) <= 32'(numBank)),
      .iAccClr   (accClr_c),
      .iDlySlice (dly[b*TAPS*IN_W +: TAPS*IN_W]),
      .oCoefRd_c (laneCoef[b]),
      .oAcc      (laneAcc[b])
    );
  end

  // Adder tree over the lane accumulators.
  always_comb begin
    sumAll_c = '0;
    for (int b = 0; b < int'(N_BANK); b++) begin
      sumAll_c = sumAll_c + laneAcc[b];
    end
  end

  // Datapath registers, outputs and status pulses.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      tapCnt       <= '0;
      dly          <= '0;
      numBank      <= '0;
      sumReg       <= '0;
      oFirOut      <= '0;
      oFirValid    <= 1'b0;
      oBusy        <= 1'b0;
      oOverrun     <= 1'b0;
      oCoeffReject <= 1'b0;
      oRdValid     <= 1'b0;
      oRdDtRam     <= '0;
    end else begin
      if (accept_c) begin
        tapCnt  <= '0;
        dly     <= {dly[DLY_W-IN_W-1:0], iFirIn};
        numBank <= iNumBank;
      end else if (runRd_c || (state == RUN)) begin
        tapCnt <= tapCnt + CNT_W'(1);
      end
      if (state == SUM) begin
        sumReg <= sumAll_c;
      end
      if (state == OUT) begin
        oFirOut <= OUT_W'(saturate(wide_t'(sumReg) >>> SHIFT, OUT_W));
      end
      oFirValid    <= (state == OUT);
      oBusy        <= (stateNext != IDLE) || (state == OUT);
      oOverrun     <= iEnSample && !idle_c;
      oCoeffReject <= (iCoeffWr || iCoeffRd) && !accessOk_c;
      oRdValid     <= rdOk_c;
      if (rdOk_c) begin
        oRdDtRam <= laneCoef[iBankSel];
      end
    end
  end

endmodule

// File: tb/tb_fir_reconf_param.sv
// Randomized self-checking bench for fir_reconf_param against a plain-arithmetic FIR model.
module tb_fir_reconf_param;

  logic              clk = 1'b0;
  logic              iRsn;
  logic              iEnSample;
  logic signed [2:0] iFirIn;
  logic [1:0]        iNumBank;
  logic              iCoeffWr;
  logic              iCoeffRd;
  logic [1:0]        iBankSel;
  logic [3:0]        iCoeffAddr;
  logic [15:0]       iWtDtRam;
  logic [15:0]       oRdDtRam;
  logic              oRdValid;
  logic [15:0]       oFirOut;
  logic              oFirValid;
  logic              oBusy;
  logic              oOverrun;
  logic              oCoeffReject;

  int checks   = 0;
  int failures = 0;

  // Reference model: coefficient table and the 40-entry sample history.
  int coefM [4][10];
  int dlyM  [40];

  always #5 clk = ~clk;

  fir_reconf_param dut (
    .iClk12M      (clk),
    .iRsn         (iRsn),
    .iEnSample    (iEnSample),
    .iFirIn       (iFirIn),
    .iNumBank     (iNumBank),
    .iCoeffWr     (iCoeffWr),
    .iCoeffRd     (iCoeffRd),
    .iBankSel     (iBankSel),
    .iCoeffAddr   (iCoeffAddr),
    .iWtDtRam     (iWtDtRam),
    .oRdDtRam     (oRdDtRam),
    .oRdValid     (oRdValid),
    .oFirOut      (oFirOut),
    .oFirValid    (oFirValid),
    .oBusy        (oBusy),
    .oOverrun     (oOverrun),
    .oCoeffReject (oCoeffReject)
  );

  function automatic void modelClear();
    for (int b = 0; b < 4; b++) for (int k = 0; k < 10; k++) coefM[b][k] = 0;
    for (int j = 0; j < 40; j++) dlyM[j] = 0;
  endfunction

  function automatic void modelShift(input int x);
    for (int j = 39; j > 0; j--) dlyM[j] = dlyM[j-1];
    dlyM[0] = x;
  endfunction

  // y = sum of c[b][k]*d[10b+k] over the active banks, clamped to 16-bit signed.
  function automatic logic [15:0] modelY(input int nb);
    longint s;
    s = 0;
    for (int b = 0; b <= nb; b++)
      for (int k = 0; k < 10; k++)
        s += longint'(coefM[b][k]) * longint'(dlyM[b*10+k]);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  task automatic writeCoef(input int b, input int a, input logic [15:0] data);
    @(negedge clk);
    iCoeffWr = 1'b1; iBankSel = 2'(b); iCoeffAddr = 4'(a); iWtDtRam = data;
    @(negedge clk);
    iCoeffWr = 1'b0;
    coefM[b][a] = int'($signed(data));
  endtask

  task automatic readCoef(input int b, input int a, output logic v, output logic [15:0] d,
                          output logic rej);
    @(negedge clk);
    iCoeffRd = 1'b1; iBankSel = 2'(b); iCoeffAddr = 4'(a);
    @(negedge clk);
    iCoeffRd = 1'b0;
    v = oRdValid; d = oRdDtRam; rej = oCoeffReject;
  endtask

  // Strobe one sample; lat = clocks from the accepting edge to oFirValid (-1 on timeout).
  task automatic sendSample(input logic signed [2:0] x, input logic [1:0] nb, output int lat,
                            output logic [15:0] y, output logic busy1);
    @(negedge clk);
    iEnSample = 1'b1; iFirIn = x; iNumBank = nb;
    @(negedge clk);
    iEnSample = 1'b0;
    busy1 = oBusy; lat = 0; y = '0;
    while (lat < 40 && !oFirValid) begin
      @(negedge clk);
      lat++;
    end
    if (oFirValid) y = oFirOut;
    else lat = -1;
  endtask

  task automatic loadRamp();
    for (int b = 0; b < 4; b++) for (int k = 0; k < 10; k++) writeCoef(b, k, 16'(10*b + k + 1));
  endtask

  task automatic test_reset();
    logic v; logic [15:0] d; logic rej;
    iRsn = 1'b0; iEnSample = 1'b0; iFirIn = '0; iNumBank = '0; iCoeffWr = 1'b0;
    iCoeffRd = 1'b0; iBankSel = '0; iCoeffAddr = '0; iWtDtRam = '0;
    modelClear();
    repeat (3) @(negedge clk);
    checks++;
    if ({oRdDtRam, oRdValid, oFirOut, oFirValid, oBusy, oOverrun, oCoeffReject} !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0",
               {oRdDtRam, oRdValid, oFirOut, oFirValid, oBusy, oOverrun, oCoeffReject});
    end
    iRsn = 1'b1;
    @(negedge clk);
    checks++;
    if (oBusy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", oBusy); end
    readCoef(3, 9, v, d, rej);
    checks++;
    if ({v, d} !== {1'b1, 16'h0000}) begin
      failures++; $display("FAIL reset_ram: got valid=%b data=%h required valid=1 data=0000", v, d);
    end
  endtask

  task automatic test_readback();
    logic v; logic [15:0] d; logic rej;
    writeCoef(2, 7, 16'hA5A5);
    readCoef(2, 7, v, d, rej);
    checks++;
    if ({v, d, rej} !== {1'b1, 16'hA5A5, 1'b0}) begin
      failures++; $display("FAIL readback: got v=%b d=%h rej=%b required v=1 d=a5a5 rej=0", v, d, rej);
    end
    @(negedge clk);
    checks++;
    if (oRdValid !== 1'b0) begin failures++; $display("FAIL rdvalid_pulse: got %b required 0", oRdValid); end
    // write and read together: write lands, read is silently dropped, old readback data held
    iCoeffWr = 1'b1; iCoeffRd = 1'b1; iBankSel = 2'd1; iCoeffAddr = 4'd2; iWtDtRam = 16'h1357;
    @(negedge clk);
    iCoeffWr = 1'b0; iCoeffRd = 1'b0;
    coefM[1][2] = 16'h1357;
    checks++;
    if ({oRdValid, oCoeffReject, oRdDtRam} !== {2'b00, 16'hA5A5}) begin
      failures++;
      $display("FAIL wr_rd_together: got v=%b rej=%b d=%h required v=0 rej=0 d=a5a5",
               oRdValid, oCoeffReject, oRdDtRam);
    end
    readCoef(1, 2, v, d, rej);
    checks++;
    if (d !== 16'h1357) begin failures++; $display("FAIL wr_wins: got %h required 1357", d); end
  endtask

  task automatic test_impulse();
    int lat; logic [15:0] y, e; logic busy1;
    loadRamp();
    for (int n = 0; n < 41; n++) begin
      modelShift(n == 0 ? 1 : 0);
      e = modelY(3);
      sendSample(3'(n == 0 ? 1 : 0), 2'd3, lat, y, busy1);
      checks++;
      if (lat !== 13) begin failures++; $display("FAIL impulse_latency[%0d]: got %0d required 13", n, lat); end
      checks++;
      if (y !== e) begin failures++; $display("FAIL impulse_out[%0d]: got %0d required %0d", n, y, e); end
      checks++;
      if (busy1 !== 1'b1) begin failures++; $display("FAIL impulse_busy[%0d]: got %b required 1", n, busy1); end
    end
    @(negedge clk);
    checks++;
    if (oBusy !== 1'b0) begin failures++; $display("FAIL busy_drop: got %b required 0", oBusy); end
  endtask

  task automatic test_length_select();
    int lat; logic [15:0] y, e;  logic busy1;
    for (int n = 0; n < 14; n++) begin
      modelShift(n == 0 ? 1 : 0);
      e = modelY(0);
      sendSample(3'(n == 0 ? 1 : 0), 2'd0, lat, y, busy1);
      checks++;
      if (y !== e || lat !== 13) begin
        failures++; $display("FAIL length_sel[%0d]: got y=%0d lat=%0d required y=%0d lat=13", n, y, lat, e);
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [15:0] y, e; logic busy1; logic signed [2:0] x; logic [1:0] nb;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 10; k++) writeCoef(b, k, 16'($urandom_range(0, 2000) - 1000));
    for (int n = 0; n < 40; n++) begin
      x = 3'($urandom);
      nb = 2'($urandom);
      modelShift(int'(x));
      e = modelY(int'(nb));
      sendSample(x, nb, lat, y, busy1);
      checks++;
      if (y !== e || lat !== 13) begin
        failures++; $display("FAIL random[%0d]: got y=%h lat=%0d required y=%h lat=13", n, y, lat, e);
      end
    end
  endtask

  task automatic test_saturation();
    int lat; logic [15:0] y, e; logic busy1;
    for (int b = 0; b < 4; b++) for (int k = 0; k < 10; k++) writeCoef(b, k, 16'h7FFF);
    for (int n = 0; n < 80; n++) begin
      modelShift(n < 40 ? 3 : -4);
      e = modelY(3);
      sendSample(n < 40 ? 3'sd3 : -3'sd4, 2'd3, lat, y, busy1);
      checks++;
      if (y !== e) begin failures++; $display("FAIL saturation[%0d]: got %h required %h", n, y, e); end
      if (n == 39) begin
        checks++;
        if (y !== 16'h7FFF) begin failures++; $display("FAIL sat_pos: got %h required 7fff", y); end
      end
      if (n == 79) begin
        checks++;
        if (y !== 16'h8000) begin failures++; $display("FAIL sat_neg: got %h required 8000", y); end
      end
    end
  endtask

  task automatic test_overrun();
    int lat; int waitCnt; logic [15:0] y, e; logic busy1;
    loadRamp();
    @(negedge clk);
    iEnSample = 1'b1; iFirIn = 3'sd1; iNumBank = 2'd3;
    modelShift(1);
    e = modelY(3);
    @(negedge clk);
    iEnSample = 1'b0;
    repeat (4) @(negedge clk);
    iEnSample = 1'b1; iFirIn = -3'sd2;
    @(negedge clk);
    iEnSample = 1'b0;
    checks++;
    if (oOverrun !== 1'b1) begin failures++; $display("FAIL overrun_pulse: got %b required 1", oOverrun); end
    @(negedge clk);
    checks++;
    if (oOverrun !== 1'b0) begin failures++; $display("FAIL overrun_clear: got %b required 0", oOverrun); end
    waitCnt = 0;
    while (waitCnt < 20 && !oFirValid) begin @(negedge clk); waitCnt++; end
    checks++;
    if (oFirValid !== 1'b1 || oFirOut !== e) begin
      failures++; $display("FAIL overrun_out: got valid=%b y=%0d required valid=1 y=%0d", oFirValid, oFirOut, e);
    end
    modelShift(0);
    e = modelY(3);
    sendSample(3'sd0, 2'd3, lat, y, busy1);
    checks++;
    if (y !== e) begin failures++; $display("FAIL overrun_dly_kept: got %0d required %0d", y, e); end
  endtask

  task automatic test_reject();
    int lat; int waitCnt; logic [15:0] y, e, d; logic busy1, v, rej;
    // write while a computation is running
    @(negedge clk);
    iEnSample = 1'b1; iFirIn = 3'sd2; iNumBank = 2'd3;
    modelShift(2);
    e = modelY(3);
    @(negedge clk);
    iEnSample = 1'b0;
    @(negedge clk);
    iCoeffWr = 1'b1; iBankSel = 2'd0; iCoeffAddr = 4'd0; iWtDtRam = 16'h1234;
    @(negedge clk);
    iCoeffWr = 1'b0;
    checks++;
    if (oCoeffReject !== 1'b1) begin failures++; $display("FAIL reject_busy: got %b required 1", oCoeffReject); end
    waitCnt = 0;
    while (waitCnt < 20 && !oFirValid) begin @(negedge clk); waitCnt++; end
    checks++;
    if (oFirOut !== e) begin failures++; $display("FAIL reject_busy_out: got %0d required %0d", oFirOut, e); end
    readCoef(0, 0, v, d, rej);
    checks++;
    if (d !== 16'(coefM[0][0])) begin failures++; $display("FAIL reject_busy_ram: got %h required %h", d, 16'(coefM[0][0])); end
    // tap index out of range
    @(negedge clk);
    iCoeffWr = 1'b1; iBankSel = 2'd1; iCoeffAddr = 4'd12; iWtDtRam = 16'hFFFF;
    @(negedge clk);
    iCoeffWr = 1'b0;
    checks++;
    if (oCoeffReject !== 1'b1) begin failures++; $display("FAIL reject_addr: got %b required 1", oCoeffReject); end
    readCoef(1, 12, v, d, rej);
    checks++;
    if ({v, rej} !== 2'b01) begin failures++; $display("FAIL reject_rd_addr: got v=%b rej=%b required v=0 rej=1", v, rej); end
    // sample and write in the same idle cycle: sample wins
    @(negedge clk);
    iEnSample = 1'b1; iFirIn = -3'sd1; iNumBank = 2'd3;
    iCoeffWr = 1'b1; iBankSel = 2'd1; iCoeffAddr = 4'd1; iWtDtRam = 16'h0BAD;
    modelShift(-1);
    e = modelY(3);
    @(negedge clk);
    iEnSample = 1'b0; iCoeffWr = 1'b0;
    checks++;
    if ({oCoeffReject, oBusy} !== 2'b11) begin
      failures++; $display("FAIL sample_wins: got rej=%b busy=%b required rej=1 busy=1", oCoeffReject, oBusy);
    end
    lat = 0;
    while (lat < 40 && !oFirValid) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 13 || oFirOut !== e) begin
      failures++; $display("FAIL sample_wins_out: got y=%0d lat=%0d required y=%0d lat=13", oFirOut, lat, e);
    end
    readCoef(1, 1, v, d, rej);
    checks++;
    if (d !== 16'(coefM[1][1])) begin failures++; $display("FAIL sample_wins_ram: got %h required %h", d, 16'(coefM[1][1])); end
  endtask

  task automatic test_reset_midrun();
    int lat; int seenValid; logic [15:0] y, d; logic busy1, v, rej;
    @(negedge clk);
    iEnSample = 1'b1; iFirIn = 3'sd3; iNumBank = 2'd3;
    @(negedge clk);
    iEnSample = 1'b0;
    repeat (3) @(negedge clk);
    iRsn = 1'b0;
    modelClear();
    @(negedge clk);
    checks++;
    if ({oRdDtRam, oRdValid, oFirOut, oFirValid, oBusy, oOverrun, oCoeffReject} !== 35'd0) begin
      failures++;
      $display("FAIL midrun_reset_outputs: got %h required 0",
               {oRdDtRam, oRdValid, oFirOut, oFirValid, oBusy, oOverrun, oCoeffReject});
    end
    @(negedge clk);
    iRsn = 1'b1;
    seenValid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (oFirValid) seenValid++;
    end
    checks++;
    if (seenValid !== 0) begin failures++; $display("FAIL midrun_no_valid: got %0d pulses required 0", seenValid); end
    readCoef(1, 3, v, d, rej);
    checks++;
    if (d !== 16'h0000) begin failures++; $display("FAIL midrun_ram_cleared: got %h required 0000", d); end
    modelShift(1);
    sendSample(3'sd1, 2'd3, lat, y, busy1);
    checks++;
    if (y !== modelY(3) || lat !== 13) begin
      failures++; $display("FAIL midrun_impulse: got y=%0d lat=%0d required y=%0d lat=13", y, lat, modelY(3));
    end
  endtask

  initial begin
    test_reset();
    test_readback();
    test_impulse();
    test_length_select();
    test_random();
    test_saturation();
    test_overrun();
    test_reject();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
